// File: rtl/alu_result_pipe.sv
// alu_result_pipe
//   Adder stage of a word-serial ALU. The sum is produced combinationally and
//   driven onto a tri-state result bus. A small flag register records the
//   status of each qualified operation. The carry-select and logic-carry
//   controls arrive CTRL_DELAY cycles ahead of the operands, so each one passes
//   through a delay chain before it is used.
//
// Ports
//   AluClock          sole clock, rising edge
//   AluReset          synchronous, active-high reset
//   Shift, Logic      adder operands (LHS, RHS)
//   OpValid           qualifies the operands as a real operation this cycle
//   CarrySel          carry-in mode: 0 -> 0, 1 -> chained carry, 2 -> 1, 3 -> 0
//   LCarryNew         logic-unit carry, reported on Flags_4_CarryL once delayed
//   Alu_Assert        active-low bus drive enable
//   MainBus           result bus, high-impedance when not asserted
//   Flags_*           registered overflow/sign/zero/carry, plus delayed logic carry

module alu_result_pipe #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned CTRL_DELAY = 1
) (
    input  logic             AluClock,
    input  logic             AluReset,
    input  logic [WIDTH-1:0] Shift,
    input  logic [WIDTH-1:0] Logic,
    input  logic             OpValid,
    input  logic [1:0]       CarrySel,
    input  logic             LCarryNew,
    input  logic             Alu_Assert,
    output tri   [WIDTH-1:0] MainBus,
    output logic             Flags_0_Overflow,
    output logic             Flags_1_Sign,
    output logic             Flags_2_Zero,
    output logic             Flags_3_CarryA,
    output logic             Flags_4_CarryL
);

    if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
        $error("alu_result_pipe: WIDTH must be in 4..32");
    end
    if (CTRL_DELAY < 1 || CTRL_DELAY > 4) begin : g_bad_delay
        $error("alu_result_pipe: CTRL_DELAY must be in 1..4");
    end

    // ------------------------------------------------------------------
    // Control delay chains
    // ------------------------------------------------------------------
    logic [1:0] cs_pipe_q [CTRL_DELAY];
    logic [1:0] cs_pipe_d [CTRL_DELAY];
    logic       lc_pipe_q [CTRL_DELAY];
    logic       lc_pipe_d [CTRL_DELAY];

    always_comb begin
        cs_pipe_d[0] = CarrySel;
        lc_pipe_d[0] = LCarryNew;
        for (int i = 1; i < int'(CTRL_DELAY); i++) begin
            cs_pipe_d[i] = cs_pipe_q[i-1];
            lc_pipe_d[i] = lc_pipe_q[i-1];
        end
    end

    logic [1:0] carry_sel_dly;
    logic       lcarry_dly;

    assign carry_sel_dly = cs_pipe_q[CTRL_DELAY-1];
    assign lcarry_dly    = lc_pipe_q[CTRL_DELAY-1];

    // ------------------------------------------------------------------
    // Chain state and flags
    // ------------------------------------------------------------------
    logic       acarry_prev_q, acarry_prev_d;
    logic       zero_prev_q, zero_prev_d;
    logic       ovf_q, ovf_d;
    logic       sign_q, sign_d;
    logic       zero_q, zero_d;
    logic       carry_q, carry_d;

    // ------------------------------------------------------------------
    // Adder
    // ------------------------------------------------------------------
    logic             carry_in;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    logic             carry_out;
    logic             overflow;
    logic             zero_now;

    always_comb begin
        carry_in = 1'b0;
        unique case (carry_sel_dly)
            2'd0:    carry_in = 1'b0;
            2'd1:    carry_in = acarry_prev_q;
            2'd2:    carry_in = 1'b1;
            default: carry_in = 1'b0;  // reserved encoding
        endcase
    end

    assign sum       = {1'b0, Shift} + {1'b0, Logic} + {{WIDTH{1'b0}}, carry_in};
    assign res       = sum[WIDTH-1:0];
    assign carry_out = sum[WIDTH];
    assign overflow  = (res[WIDTH-1] ^ Shift[WIDTH-1]) & (res[WIDTH-1] ^ Logic[WIDTH-1]);

    // A chained word is only zero if every lower word of the chain was zero.
    assign zero_now  = (res == '0) & ((carry_sel_dly == 2'd1) ? zero_prev_q : 1'b1);

    // Bus follows the result with no latency; OpValid and reset do not gate it.
    assign MainBus = Alu_Assert ? {WIDTH{1'bz}} : res;

    always_comb begin
        acarry_prev_d = acarry_prev_q;
        zero_prev_d   = zero_prev_q;
        ovf_d         = ovf_q;
        sign_d        = sign_q;
        zero_d        = zero_q;
        carry_d       = carry_q;
        if (OpValid) begin
            acarry_prev_d = carry_out;
            zero_prev_d   = zero_now;
            ovf_d         = overflow;
            sign_d        = res[WIDTH-1];
            zero_d        = zero_now;
            carry_d       = carry_out;
        end
    end

    always_ff @(posedge AluClock) begin
        if (AluReset) begin
            for (int i = 0; i < int'(CTRL_DELAY); i++) begin
                cs_pipe_q[i] <= 2'd0;
                lc_pipe_q[i] <= 1'b0;
            end
            acarry_prev_q <= 1'b0;
            zero_prev_q   <= 1'b1;
            ovf_q         <= 1'b0;
            sign_q        <= 1'b0;
            zero_q        <= 1'b0;
            carry_q       <= 1'b0;
        end else begin
            for (int i = 0; i < int'(CTRL_DELAY); i++) begin
                cs_pipe_q[i] <= cs_pipe_d[i];
                lc_pipe_q[i] <= lc_pipe_d[i];
            end
            acarry_prev_q <= acarry_prev_d;
            zero_prev_q   <= zero_prev_d;
            ovf_q         <= ovf_d;
            sign_q        <= sign_d;
            zero_q        <= zero_d;
            carry_q       <= carry_d;
        end
    end

    assign Flags_0_Overflow = ovf_q;
    assign Flags_1_Sign     = sign_q;
    assign Flags_2_Zero     = zero_q;
    assign Flags_3_CarryA   = carry_q;
    assign Flags_4_CarryL   = lcarry_dly;

endmodule

// File: tb/tb_alu_result_pipe.sv
// tb_alu_result_pipe
//   Directed-vector bench for alu_result_pipe (WIDTH=8, CTRL_DELAY=1).
//   Each vector holds the inputs for one cycle and the hand-computed outputs
//   expected in that same cycle: the bus value (or Z) and the five flags as
//   left by the previous edge. CarrySel in a vector applies to the operands
//   of the following vector. The driver pushes each vector's expectations
//   into a queue; a monitor pops and compares on every falling edge.

module tb_alu_result_pipe;

    localparam int unsigned W = 8;

    typedef struct {
        logic         rst;
        logic         opv;
        logic [W-1:0] sh;
        logic [W-1:0] lg;
        logic [1:0]   cs;
        logic         lcn;
        logic         an;      // Alu_Assert (active low)
        logic [1:0]   bmode;   // 0 none, 1 value, 2 high-Z
        logic [W-1:0] bus;
        logic         fchk;
        logic [4:0]   flags;   // {CarryL, CarryA, Zero, Sign, Overflow}
    } vec_t;

    typedef struct {
        int           idx;
        logic [1:0]   bmode;
        logic [W-1:0] bus;
        logic         fchk;
        logic [4:0]   flags;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [W-1:0] sh;
    logic [W-1:0] lg;
    logic         opv;
    logic [1:0]   cs;
    logic         lcn;
    logic         an;
    wire  [W-1:0] main_bus;
    logic         f_ovf, f_sign, f_zero, f_carry, f_lcarry;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    alu_result_pipe #(
        .WIDTH      (W),
        .CTRL_DELAY (1)
    ) dut (
        .AluClock         (clk),
        .AluReset         (rst),
        .Shift            (sh),
        .Logic            (lg),
        .OpValid          (opv),
        .CarrySel         (cs),
        .LCarryNew        (lcn),
        .Alu_Assert       (an),
        .MainBus          (main_bus),
        .Flags_0_Overflow (f_ovf),
        .Flags_1_Sign     (f_sign),
        .Flags_2_Zero     (f_zero),
        .Flags_3_CarryA   (f_carry),
        .Flags_4_CarryL   (f_lcarry)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: compare on every falling edge whenever an expectation is queued.
    initial begin
        exp_t         e;
        logic [4:0]   fl;
        logic [W-1:0] zpat;
        zpat = 8'bzzzz_zzzz;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                fl = {f_lcarry, f_carry, f_zero, f_sign, f_ovf};
                if (e.bmode == 2'd1) begin
                    n_cmp++;
                    if (main_bus !== e.bus) begin
                        n_fail++;
                        $display("FAIL bus_v%0d: got %h expected %h", e.idx, main_bus, e.bus);
                    end
                end else if (e.bmode == 2'd2) begin
                    n_cmp++;
                    if (main_bus !== zpat) begin
                        n_fail++;
                        $display("FAIL busz_v%0d: got %h expected zz", e.idx, main_bus);
                    end
                end
                if (e.fchk) begin
                    n_cmp++;
                    if (fl !== e.flags) begin
                        n_fail++;
                        $display("FAIL flags_v%0d: got %b expected %b (L C Z S V)",
                                 e.idx, fl, e.flags);
                    end
                end
            end
        end
    end

    // Driver
    initial begin
        rst = 1'b1; opv = 1'b0; sh = '0; lg = '0; cs = 2'd0; lcn = 1'b0; an = 1'b1;

        //                     rst opv sh     lg     cs  lcn an bm  bus   fc flags
        // reset; first cycle unchecked, second checks cleared state and Z bus
        vecs.push_back(vec_t'{1, 0, 8'h00, 8'h00, 0, 0, 1, 0, 8'h00, 0, 5'b00000}); // v0
        vecs.push_back(vec_t'{1, 0, 8'h00, 8'h00, 0, 1, 1, 2, 8'h00, 1, 5'b00000}); // v1
        // 0x12 + 0x34 with bus enabled, zero latency
        vecs.push_back(vec_t'{0, 0, 8'h12, 8'h34, 0, 1, 0, 1, 8'h46, 1, 5'b00000}); // v2
        // 16-bit 0x01FF + 0x0001
        vecs.push_back(vec_t'{0, 1, 8'hFF, 8'h01, 1, 0, 0, 1, 8'h00, 1, 5'b10000}); // v3
        vecs.push_back(vec_t'{0, 1, 8'h01, 8'h00, 0, 0, 0, 1, 8'h02, 1, 5'b01100}); // v4
        // chained zero: 0x80+0x80 then 0xFF+0x00
        vecs.push_back(vec_t'{0, 1, 8'h80, 8'h80, 1, 1, 0, 1, 8'h00, 1, 5'b00000}); // v5
        vecs.push_back(vec_t'{0, 1, 8'hFF, 8'h00, 0, 0, 0, 1, 8'h00, 1, 5'b11101}); // v6
        // low word non-zero: high word Res=0 but chained zero must clear
        vecs.push_back(vec_t'{0, 1, 8'h81, 8'h80, 1, 0, 0, 1, 8'h01, 1, 5'b01100}); // v7
        vecs.push_back(vec_t'{0, 1, 8'hFF, 8'h00, 2, 0, 0, 1, 8'h00, 1, 5'b01001}); // v8
        // forced carry-in: 0x7F + 0x00 + 1
        vecs.push_back(vec_t'{0, 1, 8'h7F, 8'h00, 0, 0, 0, 1, 8'h80, 1, 5'b01000}); // v9
        vecs.push_back(vec_t'{0, 0, 8'h00, 8'h00, 0, 0, 1, 2, 8'h00, 1, 5'b00011}); // v10
        // chain with three bubbles between words
        vecs.push_back(vec_t'{0, 1, 8'hFF, 8'h01, 1, 0, 0, 1, 8'h00, 1, 5'b00011}); // v11
        vecs.push_back(vec_t'{0, 0, 8'h00, 8'h00, 1, 0, 0, 1, 8'h01, 1, 5'b01100}); // v12
        vecs.push_back(vec_t'{0, 0, 8'h00, 8'h00, 1, 0, 0, 1, 8'h01, 1, 5'b01100}); // v13
        vecs.push_back(vec_t'{0, 0, 8'h00, 8'h00, 1, 0, 0, 1, 8'h01, 1, 5'b01100}); // v14
        vecs.push_back(vec_t'{0, 1, 8'h00, 8'h00, 0, 0, 0, 1, 8'h01, 1, 5'b01100}); // v15
        // reset between words (asserted together with OpValid)
        vecs.push_back(vec_t'{0, 1, 8'hFF, 8'h01, 1, 0, 0, 1, 8'h00, 1, 5'b00000}); // v16
        vecs.push_back(vec_t'{1, 1, 8'h00, 8'h00, 1, 0, 0, 1, 8'h01, 1, 5'b01100}); // v17
        vecs.push_back(vec_t'{0, 0, 8'h00, 8'h00, 1, 0, 0, 1, 8'h00, 1, 5'b00000}); // v18
        vecs.push_back(vec_t'{0, 1, 8'h00, 8'h00, 0, 0, 0, 1, 8'h00, 1, 5'b00000}); // v19
        // logic carry tracks its delayed input regardless of OpValid
        vecs.push_back(vec_t'{0, 0, 8'h00, 8'h00, 0, 1, 1, 2, 8'h00, 1, 5'b00100}); // v20
        vecs.push_back(vec_t'{0, 0, 8'h00, 8'h00, 0, 0, 1, 2, 8'h00, 1, 5'b10100}); // v21
        vecs.push_back(vec_t'{0, 0, 8'h00, 8'h00, 0, 0, 1, 2, 8'h00, 1, 5'b00100}); // v22

        foreach (vecs[k]) begin
            @(posedge clk);
            #1;
            rst = vecs[k].rst;
            opv = vecs[k].opv;
            sh  = vecs[k].sh;
            lg  = vecs[k].lg;
            cs  = vecs[k].cs;
            lcn = vecs[k].lcn;
            an  = vecs[k].an;
            exp_q.push_back(exp_t'{k, vecs[k].bmode, vecs[k].bus, vecs[k].fchk, vecs[k].flags});
        end

        // Let the monitor drain, bounded.
        for (int t = 0; t < 10 && exp_q.size() > 0; t++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
